div_unit: RTL and testbench

Multi-cycle 32-bit integer divider that services the DIV/DIVU requests issued by the execute stage and returns the HI (remainder) and LO (quotient) values that the pipeline carries through memory and writeback into the HI/LO registers. It uses a radix-2 restoring algorithm and produces one quotient bit per cycle. It exposes a start/busy/done handshake, which the hazard unit uses to stall MFHI/MFLO until the result is ready. It sits beside the ALU in the execute stage. It is the responder to the pipeline's divide request.

---
 rtl/div_unit.sv | 103 ++++++++++
 tb/tb_div_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU. Produces one quotient
// bit per cycle. Quotient is returned on div_lo and remainder on div_hi.
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_e,
    input  logic        is_signed_e,
    input  logic [31:0] dividend_e,
    input  logic [31:0] divisor_e,
    input  logic        abort_e,
    output logic        busy,
    output logic        done,
    output logic [31:0] div_hi,
    output logic [31:0] div_lo
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              state, state_next;
    logic                accept;
    logic [4:0]          count;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   dvsr;
    logic                q_neg, r_neg, div_zero;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     trial;

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                     input logic is_signed);
        return (is_signed && v[DATA_W-1]) ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                      input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign accept = (state == IDLE) && start_e && !abort_e;

    // The remainder stays below the divisor, so 32 stored bits plus a 33-bit trial suffice.
    assign shifted = {rem, quo[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvsr};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (count == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_e) state_next = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            div_hi <= '0;
            div_lo <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= 1'b0;
            if (accept)
                count <= '0;
            else if (state == RUN)
                count <= count + 5'd1;
            if (state == FIX && !abort_e) begin
                done   <= 1'b1;
                div_lo <= div_zero ? '1 : apply_sign(quo, q_neg);
                div_hi <= apply_sign(rem, r_neg);
            end
        end
    end

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            quo      <= magnitude(dividend_e, is_signed_e);
            dvsr     <= magnitude(divisor_e, is_signed_e);
            rem      <= '0;
            q_neg    <= is_signed_e & (dividend_e[DATA_W-1] ^ divisor_e[DATA_W-1]);
            r_neg    <= is_signed_e & dividend_e[DATA_W-1];
            div_zero <= (divisor_e == '0);
        end else if (state == RUN) begin
            if (!trial[DATA_W]) begin
                rem <= trial[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
                rem <= shifted[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: random and directed DIV/DIVU requests checked
// against an arithmetic reference model, plus abort, start-while-busy and reset cases.
module tb_div_unit;
    logic        clock = 0;
    logic        reset;
    logic        start_e;
    logic        is_signed_e;
    logic [31:0] dividend_e;
    logic [31:0] divisor_e;
    logic        abort_e;
    logic        busy;
    logic        done;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          k;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    div_unit dut (
        .clock(clock), .reset(reset), .start_e(start_e), .is_signed_e(is_signed_e),
        .dividend_e(dividend_e), .divisor_e(divisor_e), .abort_e(abort_e),
        .busy(busy), .done(done), .div_hi(div_hi), .div_lo(div_lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] hi, output logic [31:0] lo);
        int sa, sb_;
        if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                sa  = a;
                sb_ = b;
                lo  = sa / sb_;
                hi  = sa % sb_;
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (done) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with no request outstanding", cyc);
            end else begin
                e = sb.pop_front();
                if (div_hi !== e.hi || div_lo !== e.lo) begin
                    errors++;
                    $display("FAIL result: hi=0x%08h lo=0x%08h expected hi=0x%08h lo=0x%08h",
                             div_hi, div_lo, e.hi, e.lo);
                end
                checks++;
                if (cyc != e.k + 33) begin
                    errors++;
                    $display("FAIL latency: done after edge %0d expected %0d", cyc, e.k + 33);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit expect_it);
        exp_t e;
        @(posedge clock);
        #1;
        dividend_e  = a;
        divisor_e   = b;
        is_signed_e = s;
        start_e     = 1'b1;
        @(posedge clock);
        #1;
        start_e = 1'b0;
        if (expect_it) begin
            model(a, b, s, e.hi, e.lo);
            e.k = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(output int busy_cycles);
        bit found = 0;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) begin
                found = 1;
                break;
            end
            if (busy) busy_cycles++;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen within 60 cycles");
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        issue(a, b, s, 1'b1);
        wait_done(n);
        check("busy_cycles", n, 33);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        reset = 1'b1;
        start_e = 0; is_signed_e = 0; dividend_e = 0; divisor_e = 0; abort_e = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", div_hi, 32'd0);
        check("reset_lo", div_lo, 32'd0);

        run_op(32'd100, 32'd7, 1'b0);
        check("u100_7_lo", div_lo, 32'd14);
        check("u100_7_hi", div_hi, 32'd2);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        check("s_m7_2_lo", div_lo, 32'hFFFF_FFFD);
        check("s_m7_2_hi", div_hi, 32'hFFFF_FFFF);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
        check("s_7_m2_lo", div_lo, 32'hFFFF_FFFD);
        check("s_7_m2_hi", div_hi, 32'd1);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
        check("u_fff9_2_lo", div_lo, 32'h7FFF_FFFC);
        run_op(32'h1234_5678, 32'd0, 1'b0);
        check("u_div0_hi", div_hi, 32'h1234_5678);
        run_op(32'h1234_5678, 32'd0, 1'b1);
        check("s_div0_lo", div_lo, 32'hFFFF_FFFF);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("s_ovf_lo", div_lo, 32'h8000_0000);
        check("s_ovf_hi", div_hi, 32'd0);
        run_op(32'hFFFF_FFF0, 32'd0, 1'b1);

        // Abort mid-run: no done, results hold.
        run_op(32'd9, 32'd4, 1'b0);
        issue(32'd50, 32'd5, 1'b0, 1'b0);
        repeat (9) @(posedge clock);
        #1 abort_e = 1'b1;
        @(posedge clock);
        #1 abort_e = 1'b0;
        @(negedge clock);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (40) @(negedge clock);
        check("abort_hold_lo", div_lo, 32'd2);
        check("abort_hold_hi", div_hi, 32'd1);

        // Abort together with start in IDLE: nothing captured.
        @(posedge clock);
        #1 begin start_e = 1'b1; abort_e = 1'b1; dividend_e = 32'd77; divisor_e = 32'd3; end
        @(posedge clock);
        #1 begin start_e = 1'b0; abort_e = 1'b0; end
        @(negedge clock);
        check("abort_start_busy", {31'd0, busy}, 32'd0);

        // Start while busy is ignored.
        issue(32'd50, 32'd5, 1'b0, 1'b1);
        repeat (5) @(posedge clock);
        #1 begin start_e = 1'b1; dividend_e = 32'd99; divisor_e = 32'd9; end
        @(posedge clock);
        #1 start_e = 1'b0;
        wait_done(n);
        check("busy_start_lo", div_lo, 32'd10);
        check("busy_start_hi", div_hi, 32'd0);
        repeat (40) @(negedge clock);

        // Reset mid-run.
        issue(32'd1234, 32'd5, 1'b0, 1'b0);
        repeat (15) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_hi", div_hi, 32'd0);
        check("midreset_lo", div_lo, 32'd0);
        repeat (40) @(negedge clock);
        run_op(32'd1, 32'd1, 1'b0);
        check("after_reset_lo", div_lo, 32'd1);
        check("after_reset_hi", div_hi, 32'd0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 50);
                2:       b = -$urandom_range(1, 50);
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op(a, b, 1'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
